// File: rtl/decode_execute_unit_pkg.sv
// Shared encodings for the decode/execute slice: opcodes, function fields
// and the ALU control codes driven onto alu_control_signal.
package decode_execute_unit_pkg;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_DOUBLE  = 3'b011;
  localparam logic [2:0] F3_BEQ     = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

endpackage

// File: rtl/decode_execute_unit_mux2_xlen.sv
// Width-parameterised 2:1 mux used to pick ALU operand B.
module mux2_xlen #(
  parameter int WIDTH = 64
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] y
);

  // sel=1 selects in1, otherwise in0
  assign y = sel ? in1 : in0;

endmodule

// File: rtl/decode_execute_unit.sv
// Single-cycle decode + execute: decodes one instruction, runs the ALU,
// computes the next PC and holds the PC register (the only state).
module decode_execute_unit
  import decode_execute_unit_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [31:0]     instruction,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] pc,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      write_addr,
  output logic [3:0]      alu_control_signal,
  output logic            ALUSrc,
  output logic            RegWrite,
  output logic            MemRead,
  output logic            MemtoReg,
  output logic            MemWrite,
  output logic            Branch,
  output logic [XLEN-1:0] immediate,
  output logic [XLEN-1:0] alu_output,
  output logic [XLEN-1:0] next_PC,
  output logic            zero,
  output logic            invOp,
  output logic            invFunc,
  output logic            invRegAddr
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] operand_b;

  assign opcode     = instruction[6:0];
  assign funct3     = instruction[14:12];
  assign funct7     = instruction[31:25];
  assign rs1        = instruction[19:15];
  assign rs2        = instruction[24:20];
  assign write_addr = instruction[11:7];

  assign imm_i = {{(XLEN-12){instruction[31]}}, instruction[31:20]};
  assign imm_s = {{(XLEN-12){instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign imm_b = {{(XLEN-13){instruction[31]}}, instruction[31], instruction[7],
                  instruction[30:25], instruction[11:8], 1'b0};

  // Decode: illegal encodings leave every control at 0 and the ALU on ADD
  always_comb begin
    alu_control_signal = ALU_ADD;
    ALUSrc    = 1'b0;
    RegWrite  = 1'b0;
    MemRead   = 1'b0;
    MemtoReg  = 1'b0;
    MemWrite  = 1'b0;
    Branch    = 1'b0;
    immediate = '0;
    invOp     = 1'b0;
    invFunc   = 1'b0;
    case (opcode)
      OPC_RTYPE: begin
        if (funct3 == F3_ADD_SUB && funct7 == F7_BASE) begin
          RegWrite = 1'b1;
        end else if (funct3 == F3_ADD_SUB && funct7 == F7_ALT) begin
          alu_control_signal = ALU_SUB;
          RegWrite = 1'b1;
        end else if (funct3 == F3_AND && funct7 == F7_BASE) begin
          alu_control_signal = ALU_AND;
          RegWrite = 1'b1;
        end else if (funct3 == F3_OR && funct7 == F7_BASE) begin
          alu_control_signal = ALU_OR;
          RegWrite = 1'b1;
        end else begin
          invFunc = 1'b1;
        end
      end
      OPC_LOAD: begin
        if (funct3 == F3_DOUBLE) begin
          ALUSrc    = 1'b1;
          RegWrite  = 1'b1;
          MemRead   = 1'b1;
          MemtoReg  = 1'b1;
          immediate = imm_i;
        end else begin
          invFunc = 1'b1;
        end
      end
      OPC_STORE: begin
        if (funct3 == F3_DOUBLE) begin
          ALUSrc    = 1'b1;
          MemWrite  = 1'b1;
          immediate = imm_s;
        end else begin
          invFunc = 1'b1;
        end
      end
      OPC_BRANCH: begin
        if (funct3 == F3_BEQ) begin
          alu_control_signal = ALU_SUB;
          Branch    = 1'b1;
          immediate = imm_b;
        end else begin
          invFunc = 1'b1;
        end
      end
      default: invOp = 1'b1;
    endcase
  end

  // x0 writes are flagged but RegWrite is left visible; the register file drops them
  assign invRegAddr = RegWrite && (write_addr == 5'd0);

  mux2_xlen #(.WIDTH(XLEN)) u_operand_b_mux (
    .sel (ALUSrc),
    .in0 (rs2_data),
    .in1 (immediate),
    .y   (operand_b)
  );

  // ALU: wrapping arithmetic, no overflow reporting
  always_comb begin
    case (alu_control_signal)
      ALU_AND: alu_output = rs1_data & operand_b;
      ALU_OR:  alu_output = rs1_data | operand_b;
      ALU_SUB: alu_output = rs1_data - operand_b;
      default: alu_output = rs1_data + operand_b;
    endcase
  end

  assign zero    = (alu_output == '0);
  assign next_PC = (Branch && zero) ? pc + immediate : pc + XLEN'(4);

  // PC register: reset wins over the computed next PC
  always_ff @(posedge clock) begin
    if (reset) pc <= RESET_PC;
    else       pc <= next_PC;
  end

endmodule

// File: tb/tb_decode_execute_unit.sv
// Randomised scoreboard bench for decode_execute_unit with directed anchor cases.
module tb_decode_execute_unit;

  localparam int XLEN = 64;

  logic            clock = 1'b0;
  logic            reset;
  logic [31:0]     instruction;
  logic [XLEN-1:0] rs1_data, rs2_data;
  logic [XLEN-1:0] pc, immediate, alu_output, next_PC;
  logic [4:0]      rs1, rs2, write_addr;
  logic [3:0]      alu_control_signal;
  logic            ALUSrc, RegWrite, MemRead, MemtoReg, MemWrite, Branch;
  logic            zero, invOp, invFunc, invRegAddr;

  decode_execute_unit dut (
    .clock(clock), .reset(reset), .instruction(instruction),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .pc(pc),
    .rs1(rs1), .rs2(rs2), .write_addr(write_addr),
    .alu_control_signal(alu_control_signal),
    .ALUSrc(ALUSrc), .RegWrite(RegWrite), .MemRead(MemRead),
    .MemtoReg(MemtoReg), .MemWrite(MemWrite), .Branch(Branch),
    .immediate(immediate), .alu_output(alu_output), .next_PC(next_PC),
    .zero(zero), .invOp(invOp), .invFunc(invFunc), .invRegAddr(invRegAddr)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] pc, imm, alu, npc;
    logic [4:0]  rs1, rs2, wa;
    logic [3:0]  ctl;
    logic [5:0]  ctrl; // {ALUSrc, RegWrite, MemRead, MemtoReg, MemWrite, Branch}
    logic        zero, iop, ifn, ira;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        last_exp;
  logic [63:0] model_pc;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference model: instruction semantics written straight from the ISA rules
  function automatic exp_t model(input logic [31:0] ins, input logic [63:0] a,
                                 input logic [63:0] b, input logic [63:0] cur_pc);
    exp_t e;
    logic [6:0] opc = ins[6:0];
    logic [2:0] f3 = ins[14:12];
    logic [6:0] f7 = ins[31:25];
    logic signed [11:0] i12;
    logic signed [12:0] b13;
    longint opb;
    e.pc = cur_pc; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.wa = ins[11:7];
    e.ctl = 4'd2; e.ctrl = 6'b0; e.imm = 64'd0; e.iop = 0; e.ifn = 0;
    case (opc)
      7'h33: begin
        if (f3 == 0 && f7 == 0) e.ctl = 4'd2;
        else if (f3 == 0 && f7 == 7'h20) e.ctl = 4'd6;
        else if (f3 == 7 && f7 == 0) e.ctl = 4'd0;
        else if (f3 == 6 && f7 == 0) e.ctl = 4'd1;
        else e.ifn = 1;
        if (!e.ifn) e.ctrl = 6'b010000;
      end
      7'h03: if (f3 == 3) begin
               e.ctrl = 6'b111100; i12 = ins[31:20]; e.imm = 64'(longint'(i12));
             end else e.ifn = 1;
      7'h23: if (f3 == 3) begin
               e.ctrl = 6'b100010; i12 = {ins[31:25], ins[11:7]}; e.imm = 64'(longint'(i12));
             end else e.ifn = 1;
      7'h63: if (f3 == 0) begin
               e.ctrl = 6'b000001; e.ctl = 4'd6;
               b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
               e.imm = 64'(longint'(b13));
             end else e.ifn = 1;
      default: e.iop = 1;
    endcase
    opb = e.ctrl[5] ? e.imm : b;
    case (e.ctl)
      4'd0: e.alu = a & opb;
      4'd1: e.alu = a | opb;
      4'd6: e.alu = a - opb;
      default: e.alu = a + opb;
    endcase
    e.zero = (e.alu == 0);
    e.npc = (e.ctrl[0] && e.zero) ? cur_pc + e.imm : cur_pc + 64'd4;
    e.ira = e.ctrl[4] && (e.wa == 0);
    return e;
  endfunction

  // Applies one instruction and queues what the DUT should show this cycle
  task automatic drive(input logic [31:0] ins, input logic [63:0] a, input logic [63:0] b,
                       input logic rst);
    instruction = ins; rs1_data = a; rs2_data = b; reset = rst;
    last_exp = model(ins, a, b, model_pc);
    sb_q.push_back(last_exp);
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    model_pc = reset ? 64'd0 : last_exp.npc;
    #1;
  endtask

  // Monitor: one queued expectation is consumed each falling edge
  always @(negedge clock) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk("pc", pc, e.pc);
      chk("rs1", 64'(rs1), 64'(e.rs1));
      chk("rs2", 64'(rs2), 64'(e.rs2));
      chk("write_addr", 64'(write_addr), 64'(e.wa));
      chk("alu_ctl", 64'(alu_control_signal), 64'(e.ctl));
      chk("ctrl", 64'({ALUSrc, RegWrite, MemRead, MemtoReg, MemWrite, Branch}), 64'(e.ctrl));
      chk("immediate", immediate, e.imm);
      chk("alu_output", alu_output, e.alu);
      chk("zero", 64'(zero), 64'(e.zero));
      chk("next_PC", next_PC, e.npc);
      chk("inv_flags", 64'({invOp, invFunc, invRegAddr}), 64'({e.iop, e.ifn, e.ira}));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] ins;
    logic [63:0] a, b;
    logic [2:0]  f3;
    logic [6:0]  f7;
    reset = 1'b1; instruction = 32'h0; rs1_data = '0; rs2_data = '0;
    repeat (2) @(posedge clock);
    #1;
    model_pc = 64'd0;
    chk("reset_pc", pc, 64'd0);

    // add x1,x10,x11 at pc 0
    drive(32'h00B500B3, 64'd10, 64'd11, 1'b0);
    chk("add_alu", alu_output, 64'd21);
    chk("add_regwrite_alusrc", 64'({RegWrite, ALUSrc}), 64'b10);
    chk("add_rd", 64'(write_addr), 64'd1);
    tick();
    // sub x2,x12,x13 at pc 4
    drive(32'h40D60133, 64'd12, 64'd16, 1'b0);
    chk("sub_alu", alu_output, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("sub_zero", 64'(zero), 64'd0);
    tick();
    // ld x3,8(x4) at pc 8
    drive(32'h00823183, 64'h10, 64'h5555, 1'b0);
    chk("ld_imm", immediate, 64'd8);
    chk("ld_alu", alu_output, 64'h18);
    chk("ld_mem", 64'({MemRead, MemtoReg}), 64'b11);
    tick();
    // illegal opcode at pc 0xC
    drive(32'hFFFFFFFF, 64'h1234, 64'h1234, 1'b0);
    chk("inv_op", 64'(invOp), 64'd1);
    chk("inv_ctrl", 64'({ALUSrc, RegWrite, MemRead, MemtoReg, MemWrite, Branch}), 64'd0);
    chk("inv_npc", next_PC, 64'h10);
    tick();
    // add with rd=x0 flags invRegAddr; repeat to walk pc to 0x20
    for (int i = 0; i < 4; i++) begin
      drive(32'h00B50033, 64'd1, 64'd2, 1'b0);
      chk("x0_write", 64'({RegWrite, invRegAddr}), 64'b11);
      tick();
    end
    // beq x5,x5,+16 at pc 0x20 taken
    drive(32'h00528863, 64'd77, 64'd77, 1'b0);
    chk("beq_taken_npc", next_PC, 64'h30);
    tick();
    chk("beq_taken_pc", pc, 64'h30);
    // beq not taken at pc 0x30
    drive(32'h00528863, 64'd77, 64'd78, 1'b0);
    chk("beq_not_taken_npc", next_PC, 64'h34);
    tick();
    // three steps, then one reset edge mid-program
    for (int i = 0; i < 3; i++) begin
      drive(32'h00B500B3, 64'(i), 64'd3, 1'b0);
      tick();
    end
    drive(32'h00B500B3, 64'd4, 64'd4, 1'b1);
    tick();
    chk("mid_reset_pc", pc, 64'd0);

    // randomised traffic
    for (int n = 0; n < 400; n++) begin
      ins = $urandom;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      f3 = ins[14:12];
      f7 = ins[31:25];
      case ($urandom_range(0, 5))
        0: begin
          ins[6:0] = 7'h33;
          case ($urandom_range(0, 3))
            0: begin f3 = 3'd0; f7 = 7'h00; end
            1: begin f3 = 3'd0; f7 = 7'h20; end
            2: begin f3 = 3'd7; f7 = 7'h00; end
            default: begin f3 = 3'd6; f7 = 7'h00; end
          endcase
          ins[14:12] = f3; ins[31:25] = f7;
        end
        1: begin ins[6:0] = 7'h03; ins[14:12] = 3'd3; end
        2: begin ins[6:0] = 7'h23; ins[14:12] = 3'd3; end
        3: begin ins[6:0] = 7'h63; ins[14:12] = 3'd0; end
        4: begin
          case ($urandom_range(0, 3))
            0: ins[6:0] = 7'h33;
            1: ins[6:0] = 7'h03;
            2: ins[6:0] = 7'h23;
            default: ins[6:0] = 7'h63;
          endcase
        end
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0) b = a;
      drive(ins, a, b, ($urandom_range(0, 39) == 0));
      tick();
    end

    reset = 1'b0;
    @(negedge clock);
    #1;
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_execute_unit.md
DECODE_EXECUTE_UNIT -- requirements
Module: decode_execute_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 64: datapath width.
REQ-002 The block SHALL have parameter RESET_PC, default 0: PC value after reset.
REQ-003 The block SHALL have input clock, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have input reset, 1 bit: synchronous, active-high.
REQ-005 The block SHALL have input instruction, 32 bits: the instruction at the current PC.
REQ-006 The block SHALL have inputs rs1_data and rs2_data, XLEN bits each: register-file read data.
REQ-007 The block SHALL have output pc, XLEN bits: the current PC register.
REQ-008 The block SHALL have outputs rs1, rs2 and write_addr, 5 bits each: instruction[19:15], [24:20] and [11:7].
REQ-009 The block SHALL have output alu_control_signal, 4 bits: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB.
REQ-010 The block SHALL have outputs ALUSrc, RegWrite, MemRead, MemtoReg, MemWrite and Branch, 1 bit each.
REQ-011 The block SHALL have output immediate, XLEN bits: the sign-extended immediate.
REQ-012 The block SHALL have outputs alu_output and next_PC, XLEN bits each, and output zero, 1 bit.
REQ-013 The block SHALL have outputs invOp, invFunc and invRegAddr, 1 bit each: error flags.

Function
REQ-014 The block SHALL decode the following instructions, with all other control signals 0:
- R-type, opcode 0110011, funct3 000: funct7 0000000 is ADD (0010), funct7 0100000 is SUB (0110); RegWrite=1.
- R-type, opcode 0110011, funct7 0000000: funct3 111 is AND (0000), funct3 110 is OR (0001); RegWrite=1.
- ld, opcode 0000011, funct3 011: ALUSrc=1, RegWrite=1, MemRead=1, MemtoReg=1, ALU ADD.
- sd, opcode 0100011, funct3 011: ALUSrc=1, MemWrite=1, ALU ADD.
- beq, opcode 1100011, funct3 000: Branch=1, ALU SUB.
REQ-015 The immediate SHALL be formed by instruction type:
- I-type: sign-extended instruction[31:20].
- S-type: sign-extended {[31:25],[11:7]}.
- B-type: sign-extended {[31],[7],[30:25],[11:8],1'b0} (byte offset).
- R-type and invalid instructions: 0.
REQ-016 A 2:1 operand mux SHALL select ALU operand B as immediate when ALUSrc=1, else rs2_data.
REQ-017 alu_output SHALL equal rs1_data op operand B; ADD/SUB wrap modulo 2^XLEN with no overflow flag.
REQ-018 zero SHALL be 1 exactly when alu_output equals 0.
REQ-019 next_PC SHALL be pc+immediate when Branch and zero, else pc+4, both modulo 2^XLEN.
REQ-020 Decode, ALU and next_PC SHALL be purely combinational: results are valid in the same cycle, and pc takes next_PC at the next rising edge.
REQ-021 An unrecognised opcode SHALL set invOp=1; a recognised opcode with an illegal funct3/funct7 SHALL set invFunc=1.
REQ-022 On invOp or invFunc, all control outputs SHALL be 0, alu_control_signal SHALL be 0010, and next_PC SHALL be pc+4.
REQ-023 invRegAddr SHALL be 1 when RegWrite=1 and write_addr=0; RegWrite SHALL still be output, and the register file discards the write.

Reset
REQ-024 When reset is high at a rising edge, pc SHALL become RESET_PC, overriding next_PC.
REQ-025 Reset SHALL have no effect on combinational outputs other than through pc.
REQ-026 Reset asserted mid-program SHALL restart from RESET_PC on the following cycle.

Structure
REQ-027 A shared package SHALL hold the opcode, funct3 and funct7 constants and the four ALU control codes.
REQ-028 The operand mux SHALL be a separate sub-module mux2_xlen, parameterised by width.
REQ-029 The pc register SHALL be the only sequential element.

Verification
REQ-030 add x1,x10,x11 (0x00B500B3) with rs1_data=10 and rs2_data=11 SHALL give alu_output=21, RegWrite=1, ALUSrc=0 and write_addr=1.
REQ-031 sub x2,x12,x13 (0x40D60133) with rs1_data=12 and rs2_data=16 SHALL give alu_output=0xFFFF_FFFF_FFFF_FFFC and zero=0.
REQ-032 ld x3,8(x4) (0x00823183) with rs1_data=0x10 SHALL give immediate=8, alu_output=0x18, MemRead=1 and MemtoReg=1.
REQ-033 beq x5,x5,+16 (0x00528863) at pc=0x20 with equal operands SHALL give next_PC=0x30 and pc=0x30 after the edge; with unequal operands it SHALL give next_PC=0x24.
REQ-034 instruction 0xFFFFFFFF SHALL give invOp=1, all control outputs 0 and next_PC=pc+4.
REQ-035 Asserting reset for one edge after three steps SHALL return pc to 0.
